// File: rtl/operand_fetch.sv
// ============================================================================
// Module   : operand_fetch
// Purpose  : Decode-to-execute operand read stage with a 32-entry scoreboard
//            and write-back bypass, valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic        in_rd_we,
    output logic [4:0]  rf_ra1,
    output logic [4:0]  rf_ra2,
    input  logic [31:0] rf_rd1,
    input  logic [31:0] rf_rd2,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rs1_val,
    output logic [31:0] out_rs2_val,
    output logic [4:0]  out_rd,
    output logic        out_rd_we
);

    localparam logic [1:0] c_empty = 2'd0;
    localparam logic [1:0] c_wait  = 2'd1;
    localparam logic [1:0] c_ready = 2'd2;

    logic [1:0]  r_state;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic        r_rd_we;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic [31:0] r_pending;

    logic        w_accept;
    logic        w_handshake;
    logic        w_wb_hit1;
    logic        w_wb_hit2;
    logic        w_wb_hit_rd;
    logic        w_rs1_res;
    logic        w_rs2_res;
    logic        w_rd_clear;
    logic        w_go_ready;
    logic [31:0] w_op1;
    logic [31:0] w_op2;
    logic [31:0] w_set_mask;
    logic [31:0] w_clr_mask;
    logic [31:0] w_pending_nxt;

    assign in_ready    = !flush && ((r_state == c_empty) ||
                                    ((r_state == c_ready) && out_ready));
    assign w_accept    = in_valid && in_ready;
    assign w_handshake = (r_state == c_ready) && out_ready && !flush;

    assign rf_ra1 = (r_state == c_empty) ? 5'd0 : r_rs1;
    assign rf_ra2 = (r_state == c_empty) ? 5'd0 : r_rs2;

    // The register file may not yet reflect a write-back in its commit cycle,
    // so a write-back match always overrides the read data.
    assign w_wb_hit1   = wb_valid && (wb_rd == r_rs1);
    assign w_wb_hit2   = wb_valid && (wb_rd == r_rs2);
    assign w_wb_hit_rd = wb_valid && (wb_rd == r_rd);

    assign w_rs1_res  = (r_rs1 == 5'd0) || !r_pending[r_rs1] || w_wb_hit1;
    assign w_rs2_res  = (r_rs2 == 5'd0) || !r_pending[r_rs2] || w_wb_hit2;
    assign w_rd_clear = !r_rd_we || (r_rd == 5'd0) || !r_pending[r_rd] || w_wb_hit_rd;
    assign w_go_ready = w_rs1_res && w_rs2_res && w_rd_clear;

    assign w_op1 = (r_rs1 == 5'd0) ? 32'd0 : (w_wb_hit1 ? wb_data : rf_rd1);
    assign w_op2 = (r_rs2 == 5'd0) ? 32'd0 : (w_wb_hit2 ? wb_data : rf_rd2);

    assign out_valid   = (r_state == c_ready);
    assign out_rs1_val = r_op1;
    assign out_rs2_val = r_op2;
    assign out_rd      = r_rd;
    assign out_rd_we   = r_rd_we && (r_rd != 5'd0);

    // Set is applied after clear: the issuing instruction is younger than
    // the one writing back.
    assign w_clr_mask    = wb_valid ? (32'd1 << wb_rd) : 32'd0;
    assign w_set_mask    = (w_handshake && out_rd_we) ? (32'd1 << r_rd) : 32'd0;
    assign w_pending_nxt = ((r_pending & ~w_clr_mask) | w_set_mask) & ~32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 32'd0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state <= c_empty;
            r_rs1   <= 5'd0;
            r_rs2   <= 5'd0;
            r_rd    <= 5'd0;
            r_rd_we <= 1'b0;
            r_op1   <= 32'd0;
            r_op2   <= 32'd0;
        end else begin
            case (r_state)
                c_wait: begin
                    if (w_go_ready) begin
                        r_op1   <= w_op1;
                        r_op2   <= w_op2;
                        r_state <= c_ready;
                    end
                end
                c_empty, c_ready: begin
                    if (w_accept) begin
                        r_rs1   <= in_rs1;
                        r_rs2   <= in_rs2;
                        r_rd    <= in_rd;
                        r_rd_we <= in_rd_we;
                        r_state <= c_wait;
                    end else if (w_handshake) begin
                        r_state <= c_empty;
                    end
                end
                default: r_state <= c_empty;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// ============================================================================
// Module   : tb_operand_fetch
// Purpose  : Directed and randomized self-checking bench for operand_fetch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic        in_rd_we;
    logic [4:0]  rf_ra1;
    logic [4:0]  rf_ra2;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rs1_val;
    logic [31:0] out_rs2_val;
    logic [4:0]  out_rd;
    logic        out_rd_we;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_rd(out_rd), .out_rd_we(out_rd_we)
    );

    // Register file model; it commits a write-back only after the capture
    // edge, so operands resolved in a write-back cycle must come from bypass.
    logic [31:0] rf [32];
    assign rf_rd1 = rf[rf_ra1];
    assign rf_rd2 = rf[rf_ra2];

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       we;
    } ins_t;

    ins_t        q[$];
    logic [31:0] pend;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_hs  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample the cycle's events, advance, update the model.
    task automatic tick();
        logic        acc, hs, w;
        logic [4:0]  wr;
        logic [31:0] wd;
        ins_t        cur, e;
        @(negedge clk);
        acc = in_valid && in_ready;
        hs  = out_valid && out_ready && !flush && !rst;
        w   = wb_valid && !rst;
        wr  = wb_rd;
        wd  = wb_data;
        cur.rs1 = in_rs1; cur.rs2 = in_rs2; cur.rd = in_rd; cur.we = in_rd_we;
        e = '0;
        if (rst || flush) q.delete();
        if (hs) begin
            n_hs++;
            chk("hs_has_instr", q.size(), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("hs_op1", out_rs1_val, (e.rs1 == 5'd0) ? 32'd0 : rf[e.rs1]);
                chk("hs_op2", out_rs2_val, (e.rs2 == 5'd0) ? 32'd0 : rf[e.rs2]);
                chk("hs_rd", out_rd, e.rd);
                chk("hs_rd_we", out_rd_we, e.we && (e.rd != 5'd0));
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            pend = 32'd0;
        end else begin
            if (w && wr != 5'd0) pend[wr] = 1'b0;
            if (hs && e.we && e.rd != 5'd0) pend[e.rd] = 1'b1;
        end
        if (acc && !rst) q.push_back(cur);
        if (w && wr != 5'd0) rf[wr] = wd;
        chk("pending", dut.r_pending, pend);
    endtask

    task automatic issue(input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input logic we);
        in_valid = 1'b1; in_rs1 = s1; in_rs2 = s2; in_rd = d; in_rd_we = we;
        #1;
        chk("issue_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic writeback(input logic [4:0] r, input logic [31:0] d);
        wb_valid = 1'b1; wb_rd = r; wb_data = d;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int          cand[$];
        int          st;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_rs1 = 5'd0; in_rs2 = 5'd0;
        in_rd = 5'd0; in_rd_we = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0;
        wb_data = 32'd0; out_ready = 1'b0; pend = 32'd0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;

        // Reset state
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_op1", out_rs1_val, 0);
        chk("rst_op2", out_rs2_val, 0);
        chk("rst_rd", out_rd, 0);
        chk("rst_rd_we", out_rd_we, 0);
        chk("rst_ra1", rf_ra1, 0);
        chk("rst_ra2", rf_ra2, 0);
        rst = 1'b0;
        tick();

        // No hazard: minimum latency
        rf[1] = 32'h11; rf[2] = 32'h22;
        issue(5'd1, 5'd2, 5'd3, 1'b1);
        chk("t1_wait_valid", out_valid, 0);
        chk("t1_ra1", rf_ra1, 1);
        chk("t1_ra2", rf_ra2, 2);
        tick();
        chk("t1_valid", out_valid, 1);
        chk("t1_op1", out_rs1_val, 32'h11);
        chk("t1_op2", out_rs2_val, 32'h22);
        handshake();
        chk("t1_pend3", dut.r_pending[3], 1);
        chk("t1_empty", out_valid, 0);
        writeback(5'd3, 32'h33);

        // RAW stall resolved by bypass
        rf[5] = 32'h55;
        issue(5'd0, 5'd0, 5'd5, 1'b1);
        tick();
        handshake();
        issue(5'd5, 5'd0, 5'd6, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_stall", out_valid, 0);
        end
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        tick();
        wb_valid = 1'b0;
        chk("t2_valid", out_valid, 1);
        chk("t2_op1", out_rs1_val, 32'hDEADBEEF);
        chk("t2_pend5", dut.r_pending[5], 0);
        handshake();
        writeback(5'd6, 32'h66);

        // x0 reads as zero, x0 destination never tracked
        rf[0] = 32'hFFFFFFFF;
        issue(5'd0, 5'd0, 5'd0, 1'b1);
        tick();
        chk("t3_valid", out_valid, 1);
        chk("t3_op1", out_rs1_val, 0);
        chk("t3_op2", out_rs2_val, 0);
        chk("t3_rd_we", out_rd_we, 0);
        handshake();
        chk("t3_pend0", dut.r_pending[0], 0);

        // WAW guard
        issue(5'd0, 5'd0, 5'd7, 1'b1);
        tick();
        handshake();
        issue(5'd1, 5'd2, 5'd7, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_stall", out_valid, 0);
        end
        writeback(5'd7, 32'h77);
        chk("t4_valid", out_valid, 1);
        handshake();
        chk("t4_pend7", dut.r_pending[7], 1);
        writeback(5'd7, 32'h777);

        // Backpressure then flush
        issue(5'd1, 5'd2, 5'd8, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_hold_valid", out_valid, 1);
            chk("t5_hold_op1", out_rs1_val, 32'h11);
            chk("t5_hold_op2", out_rs2_val, 32'h22);
            chk("t5_hold_rd", out_rd, 8);
        end
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        #1;
        chk("t5_flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        #1;
        chk("t5_flush_valid", out_valid, 0);
        chk("t5_flush_in_ready_after", in_ready, 1);
        chk("t5_pend8", dut.r_pending[8], 0);

        // Same-cycle set and clear of one index
        issue(5'd0, 5'd0, 5'd9, 1'b1);
        tick();
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h99;
        handshake();
        wb_valid = 1'b0;
        chk("t6_pend9", dut.r_pending[9], 1);
        writeback(5'd9, 32'h999);

        // Randomized traffic against the model
        for (int i = 1; i < 32; i++) rf[i] = $urandom;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_rs1    = 5'($urandom_range(0, 31));
            in_rs2    = 5'($urandom_range(0, 31));
            in_rd     = 5'($urandom_range(0, 31));
            in_rd_we  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 25) == 0;
            wb_valid  = 1'b0;
            cand.delete();
            for (int r = 1; r < 32; r++) if (pend[r]) cand.push_back(r);
            if (cand.size() != 0 && ($urandom % 3) == 0) begin
                st       = int'($urandom_range(0, cand.size() - 1));
                wb_valid = 1'b1;
                wb_rd    = 5'(cand[st]);
                wb_data  = $urandom;
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; wb_valid = 1'b0;
        tick();
        chk("random_handshakes", n_hs > 40, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
